// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Load-use hazard unit with shift-register scoreboard of in-flight
//            loads, stall/flush/freeze control and saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              branch_taken,
    input  logic              dmem_busy,
    input  logic              cnt_clr,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              load_stall,
    output logic [CNT_W-1:0]  stall_cycles
);

    // Arrays are kept at least one entry wide; the LOAD_LAT=1 case never builds them.
    localparam int                c_DEPTH    = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;
    localparam logic [REG_AW-1:0] c_ZERO_REG = '0;
    localparam logic [CNT_W-1:0]  c_CNT_MAX  = '1;

    logic             w_ex_load;
    logic             w_ex_hit;
    logic             w_pend_hit;
    logic             w_hazard;
    logic [CNT_W-1:0] r_cnt;

    function automatic logic f_match(
        input logic [REG_AW-1:0] r,
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rt,
        input logic              use_rs,
        input logic              use_rt
    );
        return (r != c_ZERO_REG) && ((use_rs && (rs == r)) || (use_rt && (rt == r)));
    endfunction

    assign w_ex_load = ex_valid & ex_mem_read & (ex_rd != c_ZERO_REG);
    assign w_ex_hit  = w_ex_load & f_match(ex_rd, id_rs, id_rt, id_use_rs, id_use_rt);
    assign w_hazard  = w_ex_hit | w_pend_hit;

    generate
        if (LOAD_LAT > 1) begin : g_sb
            logic [c_DEPTH-1:0]             r_pend_v;
            logic [c_DEPTH-1:0][REG_AW-1:0] r_pend_rd;

            // Loads already past ID keep moving even while ID stalls or is flushed.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pend_v  <= '0;
                    r_pend_rd <= '0;
                end else if (!dmem_busy) begin
                    r_pend_v[0]  <= w_ex_load;
                    r_pend_rd[0] <= ex_rd;
                    for (int k = 1; k < c_DEPTH; k++) begin
                        r_pend_v[k]  <= r_pend_v[k-1];
                        r_pend_rd[k] <= r_pend_rd[k-1];
                    end
                end
            end

            always_comb begin
                w_pend_hit = 1'b0;
                for (int k = 0; k < c_DEPTH; k++) begin
                    if (r_pend_v[k] && f_match(r_pend_rd[k], id_rs, id_rt, id_use_rs, id_use_rt)) begin
                        w_pend_hit = 1'b1;
                    end
                end
            end
        end else begin : g_no_sb
            assign w_pend_hit = 1'b0;
        end
    endgenerate

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        load_stall  = 1'b0;
        if (dmem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (branch_taken) begin
            // The ID instruction is killed, so any hazard it carries is moot.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (w_hazard) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            load_stall  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (load_stall && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign stall_cycles = r_cnt;

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised load-use hazard unit for the pipelined CPU with configurable load-to-use latency. It sits beside the ID stage. It compares ID source registers against the load in EX and against a shift-register scoreboard of loads still in flight. It then drives PC/IF-ID write enables and an ID/EX bubble, handles taken-branch flushes and data-memory freezes, and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- REG_AW, 5, register-address width (2^REG_AW architectural registers; register 0 never hazards)
- LOAD_LAT, 1, stall cycles a dependent instruction needs behind a load (1..4); scoreboard depth is LOAD_LAT-1
- CNT_W, 16, width of stall counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs, id_rt  in  REG_AW  source registers of instruction in ID
- id_use_rs, id_use_rt  in  1  source actually read
- ex_valid  in  1  EX holds a real instruction (not bubble)
- ex_mem_read  in  1  EX instruction is a load
- ex_rd  in  REG_AW  load destination register
- branch_taken  in  1  taken branch/jump resolved in EX
- dmem_busy  in  1  data memory not ready; whole pipeline frozen
- cnt_clr  in  1  synchronous clear of stall counter
- pc_write  out  1  1 = PC may update
- ifid_write  out  1  1 = IF/ID may load
- ifid_flush  out  1  1 = IF/ID loads a bubble
- idex_bubble  out  1  1 = ID/EX loads a bubble (control zeroed)
- load_stall  out  1  load-use stall active this cycle
- stall_cycles  out  CNT_W  saturating count of load_stall cycles

## Operation
- ex_load = ex_valid & ex_mem_read & (ex_rd != 0).
- Scoreboard entries pend[0..LOAD_LAT-2], each {v, rd}. For LOAD_LAT=1 the scoreboard is absent.
- match(r) = (id_use_rs & id_rs == r) | (id_use_rt & id_rt == r), with r != 0.
- hazard = (ex_load & match(ex_rd)) | OR over k of (pend[k].v & match(pend[k].rd)).
- Output priority, highest first:
  - dmem_busy=1: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=0, load_stall=0. Scoreboard and counter hold. A taken branch is deferred because EX is held and branch_taken reasserts.
  - branch_taken=1: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1, load_stall=0. The ID instruction is killed, so a hazard is ignored.
  - hazard=1: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1, load_stall=1.
  - otherwise: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, load_stall=0.
- Scoreboard advance, when dmem_busy=0:
  - pend[0] <= {ex_load, ex_rd}.
  - pend[k+1] <= pend[k].
  - The oldest entry drops out.
  - Advance is independent of stall or branch, because loads already past ID proceed.
- Counter: cnt_clr=1 gives 0, taking priority over increment. Otherwise, if load_stall=1 and stall_cycles is not all-ones, it increments; it saturates at 2^CNT_W-1.
- Net effect: a consumer immediately behind a load stalls exactly LOAD_LAT cycles, and one two slots behind stalls LOAD_LAT-1 cycles (min 0).

## Timing
- All outputs except stall_cycles are combinational from inputs and scoreboard state, valid in the same cycle.
- Scoreboard and stall_cycles update on the rising clk edge; stall_cycles reflects stalls up to the previous edge.
- Reset (asynchronous, rst_n=0):
  - All pend[k].v=0 and stall_cycles=0, immediately, not waiting for clk.
  - With ex_valid=0, branch_taken=0 and dmem_busy=0: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, load_stall=0.
- Reset mid-stall drops all pending hazards.
- Release of rst_n is synchronised externally.
- During dmem_busy, stall length is measured in non-frozen cycles.

## Test plan
- LOAD_LAT=1: lw $8 in EX (ex_load, ex_rd=8), ID rs=8 use_rs=1 -> exactly 1 cycle pc_write=0/idex_bubble=1, then enables=1; stall_cycles=1.
- LOAD_LAT=3: load rd=5 then dependent id_rt=5 next cycle -> 3 consecutive stall cycles. With one independent instruction between them -> 2 stall cycles.
- ex_rd=0 or id_use_rs=id_use_rt=0 with matching field -> no stall.
- Hazard and branch_taken together -> ifid_flush=1, idex_bubble=1, pc_write=1, load_stall=0, counter unchanged.
- LOAD_LAT=2, dmem_busy=1 for 4 cycles mid-stall -> all enables 0 and scoreboard frozen. After release, the stall resumes for the remaining 1 cycle.
- CNT_W=2: 5 stall cycles -> stall_cycles=3 (saturated). cnt_clr -> 0. Assert rst_n=0 asynchronously mid-stall -> outputs return to defaults before the next edge.
